syndrome_calc: RTL and testbench
================================

# syndrome_calc

Serial syndrome generator for the binary BCH decoder. It sits directly upstream of the early-stop check and produces the odd syndromes S1, S3, S5 and S7 for each received codeword. In soft mode it also produces them for the three Chase test patterns formed by flipping the two least-reliable bit positions. It uses Horner accumulation over GF(2^m), one bit per accepted cycle.

## Interface
Parameters:
- none; field and code geometry are selected at run time by `i_code`.

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  one-cycle pulse that starts a codeword. Samples `i_mode`, `i_code`, `i_lrb1_idx` and `i_lrb2_idx`.
- `i_mode`  in  1  0 = hard decision (tp1 only), 1 = soft decision (tp1..tp4).
- `i_code`  in  2  00 = (63,51) over m=6; 01 = (255,239) over m=8; 10 = (1023,983) over m=10; 11 is reserved and treated as 10.
- `i_lrb1_idx`, `i_lrb2_idx`  in  10 each  bit positions (polynomial degree) of the two least-reliable bits.
- `i_bit_valid`  in  1  qualifies `i_bit`.
- `i_bit`  in  1  received hard bit. Bits arrive highest degree first (r[n-1] … r[0]).
- `o_tp{k}_S1`, `o_tp{k}_S3`, `o_tp{k}_S5`, `o_tp{k}_S7`  out  10 each, for k=1..4  syndromes, LSB-aligned; bits above m are 0.
- `o_tp1_valid`  out  1  level; tp1 syndromes are final.
- `o_all_tp_valid`  out  1  level; all four test-pattern syndromes are final (mode 1 only).

## Operation
- Primitive polynomials: m=6 uses x^6+x+1; m=8 uses x^8+x^4+x^3+x^2+1; m=10 uses x^10+x^3+1. α = 0x002 in every field.
- Three accumulator sets, each holding j ∈ {1,3,5,7}:
  - R: received bits.
  - A: indicator of `cnt == lrb1_idx`.
  - B: indicator of `cnt == lrb2_idx`.
- Update on each accepted bit: X_j ← X_j·α^j ⊕ in, using constant multipliers for the field selected by the latched code.
- Position counter `cnt` loads n−1 on `i_start` and decrements on each accepted bit.
- Mode 0: A and B are held at 0.
- Test-pattern combine: tp1 = R, tp2 = R⊕A, tp3 = R⊕B, tp4 = R⊕A⊕B.
- `lrb1_idx == lrb2_idx` is legal; tp4 then equals tp1.
- An LRB index ≥ n never matches, so that flip contributes 0.
- State machine:
  - IDLE → RUN on `i_start`. All accumulators clear; `cnt` = n−1.
  - RUN: each cycle with `i_bit_valid` high accepts a bit. Gaps in `i_bit_valid` are allowed.
  - RUN → DONE when the bit at `cnt == 0` is accepted.
  - DONE holds all results until the next `i_start`, then goes to RUN.
- `i_start` during RUN aborts the current word and restarts immediately. Valids stay low.
- `i_bit_valid` in IDLE or DONE is ignored.
- If `i_start` and `i_bit_valid` are high in the same cycle, the bit is ignored; the first bit is taken in a later cycle.

## Timing
- Reset values: all syndrome outputs 0, both valids 0, state IDLE, `cnt` 0.
- `o_tp1_valid` rises in the cycle after the last bit is accepted. R is the registered output, so latency is 1.
- `o_all_tp_valid` (mode 1) rises one cycle after `o_tp1_valid`, through a registered combine stage. It stays 0 in mode 0.
- In mode 0, tp2..tp4 outputs equal tp1.
- Both valids drop in the cycle after `i_start` and stay low until the new word completes.
- Reset mid-word returns to IDLE with no output.
- Minimum word time is n accepted bits, i.e. 64, 256 or 1024 cycles including the start cycle.

## Configuration
- `SYNDROME_CALC_TP_EN` defined: A/B accumulators, combine stage and tp2..tp4 outputs are present, as described above.
- `SYNDROME_CALC_TP_EN` undefined:
  - A/B accumulators and the combine stage are removed.
  - tp2..tp4 outputs are tied to 0.
  - `o_all_tp_valid` is tied to 0.
  - `i_mode` is ignored (hard only).

## Structure
- Shared package holds:
  - code-select encodings;
  - per-code n−1 values (62, 254, 1022);
  - primitive polynomial constants;
  - state encoding for IDLE/RUN/DONE.
- One sub-module: `gf_const_mul`. It multiplies a 10-bit element by α^j (j parameter) for the field selected by a 2-bit code input, as a pure XOR network. The block instantiates it 12 times: 4 powers × 3 accumulator sets.

## Test plan
- code 00, 63 zero bits → all syndromes 0x000; `o_tp1_valid` rises the cycle after bit 63.
- code 00, only r[0] = 1 → tp1 S1 = S3 = S5 = S7 = 0x001.
- code 10, only r[1] = 1 → tp1 S1 = 0x002, S3 = 0x008, S5 = 0x020, S7 = 0x080.
- code 10, mode 1, lrb1 = 1, lrb2 = 5, only r[1] = 1:
  - tp1 = {0x002, 0x008, 0x020, 0x080};
  - tp2 = all 0;
  - `o_all_tp_valid` asserts one cycle after `o_tp1_valid`.
- code 01, random word with `i_bit_valid` gaps → matches the software model. A gap-free rerun gives identical results.
- `i_rst` asserted at bit 100, then a fresh zero word → outputs 0 through reset. A clean result follows with no stale valid. Repeat with `i_start` at bit 100 instead of reset: same outcome.

Source files
------------

// File: rtl/syndrome_calc_pkg.sv
// Shared definitions for the serial BCH syndrome generator: code selects,
// word lengths, field reduction terms and FSM states.
package syndrome_calc_pkg;

   typedef enum logic [1:0] {
      CODE_63   = 2'b00,
      CODE_255  = 2'b01,
      CODE_1023 = 2'b10,
      CODE_RSVD = 2'b11
   } code_e;

   localparam logic [9:0] NM1_63   = 10'd62;
   localparam logic [9:0] NM1_255  = 10'd254;
   localparam logic [9:0] NM1_1023 = 10'd1022;

   // Primitive polynomials with the x^m term dropped (it is the shifted-out bit).
   localparam logic [9:0] POLY_63   = 10'h003;
   localparam logic [9:0] POLY_255  = 10'h01D;
   localparam logic [9:0] POLY_1023 = 10'h009;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic logic [9:0] code_nm1(input logic [1:0] code);
      logic [9:0] nm1;
      case (code)
         CODE_63:  nm1 = NM1_63;
         CODE_255: nm1 = NM1_255;
         default:  nm1 = NM1_1023;
      endcase
      return nm1;
   endfunction

   function automatic logic [9:0] gf_mul_alpha(input logic [9:0] a, input logic [1:0] code);
      logic [9:0] p;
      case (code)
         CODE_63:  p = {4'b0, a[4:0], 1'b0} ^ (a[5] ? POLY_63 : 10'h000);
         CODE_255: p = {2'b0, a[6:0], 1'b0} ^ (a[7] ? POLY_255 : 10'h000);
         default:  p = {a[8:0], 1'b0} ^ (a[9] ? POLY_1023 : 10'h000);
      endcase
      return p;
   endfunction

endpackage

// File: rtl/syndrome_calc_gf_const_mul.sv
// Constant multiplier by alpha^J in GF(2^m), field chosen by a 2-bit code.
// Unrolls to a pure XOR network.
module gf_const_mul #(
   parameter int J = 1
) (
   input  logic [1:0] i_code,
   input  logic [9:0] i_a,
   output logic [9:0] o_p
);
   import syndrome_calc_pkg::*;

   always_comb begin
      logic [9:0] p;
      p = i_a;
      for (int k = 0; k < J; k++) begin
         p = gf_mul_alpha(p, i_code);
      end
      o_p = p;
   end

endmodule

// File: rtl/syndrome_calc.sv
// Serial odd-syndrome generator (S1,S3,S5,S7) with optional Chase test patterns.
// Define SYNDROME_CALC_TP_EN to build the tp2..tp4 (soft-decision) datapath.
module syndrome_calc
   import syndrome_calc_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_mode,
   input  logic [1:0] i_code,
   input  logic [9:0] i_lrb1_idx,
   input  logic [9:0] i_lrb2_idx,
   input  logic       i_bit_valid,
   input  logic       i_bit,
   output logic [9:0] o_tp1_S1,
   output logic [9:0] o_tp1_S3,
   output logic [9:0] o_tp1_S5,
   output logic [9:0] o_tp1_S7,
   output logic [9:0] o_tp2_S1,
   output logic [9:0] o_tp2_S3,
   output logic [9:0] o_tp2_S5,
   output logic [9:0] o_tp2_S7,
   output logic [9:0] o_tp3_S1,
   output logic [9:0] o_tp3_S3,
   output logic [9:0] o_tp3_S5,
   output logic [9:0] o_tp3_S7,
   output logic [9:0] o_tp4_S1,
   output logic [9:0] o_tp4_S3,
   output logic [9:0] o_tp4_S5,
   output logic [9:0] o_tp4_S7,
   output logic       o_tp1_valid,
   output logic       o_all_tp_valid
);

   state_e     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic [1:0] code_q, code_d;
   logic       tp1_valid_q, tp1_valid_d;
   logic       accept, clear;
   logic [9:0] r_q [4];
   logic [9:0] r_d [4];
   logic [9:0] r_mul [4];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_r_mul
         gf_const_mul #(.J(2 * gi + 1)) u_mul_r (
            .i_code (code_q),
            .i_a    (r_q[gi]),
            .o_p    (r_mul[gi])
         );
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      code_d      = code_q;
      tp1_valid_d = tp1_valid_q;
      accept      = 1'b0;
      clear       = 1'b0;
      // A start always wins, so a bit presented with it is dropped.
      if (i_start) begin
         state_d     = ST_RUN;
         cnt_d       = code_nm1(i_code);
         code_d      = (i_code == CODE_RSVD) ? CODE_1023 : i_code;
         tp1_valid_d = 1'b0;
         clear       = 1'b1;
      end else if (state_q == ST_RUN && i_bit_valid) begin
         accept = 1'b1;
         if (cnt_q == 10'd0) begin
            state_d     = ST_DONE;
            tp1_valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q - 10'd1;
         end
      end
      for (int k = 0; k < 4; k++) begin
         r_d[k] = r_q[k];
         if (clear) r_d[k] = '0;
         else if (accept) r_d[k] = r_mul[k] ^ {9'b0, i_bit};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         code_q      <= '0;
         tp1_valid_q <= 1'b0;
         for (int k = 0; k < 4; k++) r_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         code_q      <= code_d;
         tp1_valid_q <= tp1_valid_d;
         r_q         <= r_d;
      end
   end

   assign o_tp1_S1    = r_q[0];
   assign o_tp1_S3    = r_q[1];
   assign o_tp1_S5    = r_q[2];
   assign o_tp1_S7    = r_q[3];
   assign o_tp1_valid = tp1_valid_q;

`ifdef SYNDROME_CALC_TP_EN
   logic       mode_q, mode_d;
   logic [9:0] lrb1_q, lrb1_d, lrb2_q, lrb2_d;
   logic       all_valid_q, all_valid_d;
   logic       a_in, b_in;
   logic [9:0] a_q [4];
   logic [9:0] a_d [4];
   logic [9:0] b_q [4];
   logic [9:0] b_d [4];
   logic [9:0] a_mul [4];
   logic [9:0] b_mul [4];
   logic [9:0] c2_q [4];
   logic [9:0] c2_d [4];
   logic [9:0] c3_q [4];
   logic [9:0] c3_d [4];
   logic [9:0] c4_q [4];
   logic [9:0] c4_d [4];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_ab_mul
         gf_const_mul #(.J(2 * gi + 1)) u_mul_a (
            .i_code (code_q),
            .i_a    (a_q[gi]),
            .o_p    (a_mul[gi])
         );
         gf_const_mul #(.J(2 * gi + 1)) u_mul_b (
            .i_code (code_q),
            .i_a    (b_q[gi]),
            .o_p    (b_mul[gi])
         );
      end
   endgenerate

   always_comb begin
      mode_d      = mode_q;
      lrb1_d      = lrb1_q;
      lrb2_d      = lrb2_q;
      // cnt never exceeds n-1, so an out-of-range index simply never fires.
      a_in        = mode_q && (cnt_q == lrb1_q);
      b_in        = mode_q && (cnt_q == lrb2_q);
      all_valid_d = tp1_valid_q && mode_q && !i_start;
      if (i_start) begin
         mode_d = i_mode;
         lrb1_d = i_lrb1_idx;
         lrb2_d = i_lrb2_idx;
      end
      for (int k = 0; k < 4; k++) begin
         a_d[k]  = a_q[k];
         b_d[k]  = b_q[k];
         c2_d[k] = r_q[k] ^ a_q[k];
         c3_d[k] = r_q[k] ^ b_q[k];
         c4_d[k] = r_q[k] ^ a_q[k] ^ b_q[k];
         if (clear) begin
            a_d[k]  = '0;
            b_d[k]  = '0;
            c2_d[k] = '0;
            c3_d[k] = '0;
            c4_d[k] = '0;
         end else if (accept) begin
            a_d[k] = a_mul[k] ^ {9'b0, a_in};
            b_d[k] = b_mul[k] ^ {9'b0, b_in};
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mode_q      <= 1'b0;
         lrb1_q      <= '0;
         lrb2_q      <= '0;
         all_valid_q <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            c2_q[k] <= '0;
            c3_q[k] <= '0;
            c4_q[k] <= '0;
         end
      end else begin
         mode_q      <= mode_d;
         lrb1_q      <= lrb1_d;
         lrb2_q      <= lrb2_d;
         all_valid_q <= all_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c2_q        <= c2_d;
         c3_q        <= c3_d;
         c4_q        <= c4_d;
      end
   end

   assign o_tp2_S1       = c2_q[0];
   assign o_tp2_S3       = c2_q[1];
   assign o_tp2_S5       = c2_q[2];
   assign o_tp2_S7       = c2_q[3];
   assign o_tp3_S1       = c3_q[0];
   assign o_tp3_S3       = c3_q[1];
   assign o_tp3_S5       = c3_q[2];
   assign o_tp3_S7       = c3_q[3];
   assign o_tp4_S1       = c4_q[0];
   assign o_tp4_S3       = c4_q[1];
   assign o_tp4_S5       = c4_q[2];
   assign o_tp4_S7       = c4_q[3];
   assign o_all_tp_valid = all_valid_q;
`else
   logic unused_soft_inputs;
   assign unused_soft_inputs = ^{i_mode, i_lrb1_idx, i_lrb2_idx};

   assign o_tp2_S1       = '0;
   assign o_tp2_S3       = '0;
   assign o_tp2_S5       = '0;
   assign o_tp2_S7       = '0;
   assign o_tp3_S1       = '0;
   assign o_tp3_S3       = '0;
   assign o_tp3_S5       = '0;
   assign o_tp3_S7       = '0;
   assign o_tp4_S1       = '0;
   assign o_tp4_S3       = '0;
   assign o_tp4_S5       = '0;
   assign o_tp4_S7       = '0;
   assign o_all_tp_valid = 1'b0;
`endif

endmodule

// File: tb/tb_syndrome_calc.sv
// Self-checking bench for syndrome_calc: random words checked against a
// direct power-sum syndrome model built from exp tables of each field.
module tb_syndrome_calc;

`ifdef SYNDROME_CALC_TP_EN
   localparam bit TP_EN = 1'b1;
`else
   localparam bit TP_EN = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst, i_start, i_mode, i_bit_valid, i_bit;
   logic [1:0] i_code;
   logic [9:0] i_lrb1_idx, i_lrb2_idx;
   logic [9:0] o_tp1_S1, o_tp1_S3, o_tp1_S5, o_tp1_S7;
   logic [9:0] o_tp2_S1, o_tp2_S3, o_tp2_S5, o_tp2_S7;
   logic [9:0] o_tp3_S1, o_tp3_S3, o_tp3_S5, o_tp3_S7;
   logic [9:0] o_tp4_S1, o_tp4_S3, o_tp4_S5, o_tp4_S7;
   logic       o_tp1_valid, o_all_tp_valid;

   int n_checks = 0;
   int n_fail   = 0;
   bit word [1024];
   logic [9:0] exp_s [4][4];
   logic [9:0] got   [4][4];

   syndrome_calc dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
      .i_code(i_code), .i_lrb1_idx(i_lrb1_idx), .i_lrb2_idx(i_lrb2_idx),
      .i_bit_valid(i_bit_valid), .i_bit(i_bit),
      .o_tp1_S1(o_tp1_S1), .o_tp1_S3(o_tp1_S3), .o_tp1_S5(o_tp1_S5), .o_tp1_S7(o_tp1_S7),
      .o_tp2_S1(o_tp2_S1), .o_tp2_S3(o_tp2_S3), .o_tp2_S5(o_tp2_S5), .o_tp2_S7(o_tp2_S7),
      .o_tp3_S1(o_tp3_S1), .o_tp3_S3(o_tp3_S3), .o_tp3_S5(o_tp3_S5), .o_tp3_S7(o_tp3_S7),
      .o_tp4_S1(o_tp4_S1), .o_tp4_S3(o_tp4_S3), .o_tp4_S5(o_tp4_S5), .o_tp4_S7(o_tp4_S7),
      .o_tp1_valid(o_tp1_valid), .o_all_tp_valid(o_all_tp_valid)
   );

   assign got[0][0] = o_tp1_S1;  assign got[0][1] = o_tp1_S3;
   assign got[0][2] = o_tp1_S5;  assign got[0][3] = o_tp1_S7;
   assign got[1][0] = o_tp2_S1;  assign got[1][1] = o_tp2_S3;
   assign got[1][2] = o_tp2_S5;  assign got[1][3] = o_tp2_S7;
   assign got[2][0] = o_tp3_S1;  assign got[2][1] = o_tp3_S3;
   assign got[2][2] = o_tp3_S5;  assign got[2][3] = o_tp3_S7;
   assign got[3][0] = o_tp4_S1;  assign got[3][1] = o_tp4_S3;
   assign got[3][2] = o_tp4_S5;  assign got[3][3] = o_tp4_S7;

   always #5 i_clk = ~i_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int n_of(input int code);
      if (code == 0) return 63;
      if (code == 1) return 255;
      return 1023;
   endfunction

   // Reference: S_j = sum of alpha^(j*i) over set bits, flips add alpha^(j*lrb).
   task automatic model(input int code, input bit mode, input int l1, input int l2);
      int m, poly, n, v;
      int alog [1023];
      n    = n_of(code);
      m    = (code == 0) ? 6 : (code == 1) ? 8 : 10;
      poly = (code == 0) ? 'h43 : (code == 1) ? 'h11D : 'h409;
      v = 1;
      for (int e = 0; e < n; e++) begin
         alog[e] = v;
         v = v << 1;
         if ((v >> m) & 1) v = v ^ poly;
      end
      for (int j = 0; j < 4; j++) begin
         int p, r, fa, fb;
         p = 2 * j + 1;
         r = 0; fa = 0; fb = 0;
         for (int i = 0; i < n; i++) if (word[i]) r = r ^ alog[(p * i) % n];
         if (mode && l1 < n) fa = alog[(p * l1) % n];
         if (mode && l2 < n) fb = alog[(p * l2) % n];
         exp_s[0][j] = r[9:0];
         if (TP_EN) begin
            exp_s[1][j] = 10'(r ^ fa);
            exp_s[2][j] = 10'(r ^ fb);
            exp_s[3][j] = 10'(r ^ fa ^ fb);
         end else begin
            exp_s[1][j] = '0;
            exp_s[2][j] = '0;
            exp_s[3][j] = '0;
         end
      end
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < 1024; i++) word[i] = (i < n) ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   task automatic fill_zero();
      for (int i = 0; i < 1024; i++) word[i] = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (got[k][j] !== 10'h000) begin
               n_fail++;
               $display("FAIL %s tp%0d S%0d: got %h expected 000", name, k + 1, 2 * j + 1, got[k][j]);
            end
         end
      n_checks++;
      if (o_tp1_valid !== 1'b0 || o_all_tp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s valids: got %b%b expected 00", name, o_tp1_valid, o_all_tp_valid);
      end
   endtask

   task automatic start_word(input int code, input bit mode, input int l1, input int l2,
                             input bit with_bit);
      @(negedge i_clk);
      i_start     = 1'b1;
      i_code      = 2'(code);
      i_mode      = mode;
      i_lrb1_idx  = 10'(l1);
      i_lrb2_idx  = 10'(l2);
      i_bit_valid = with_bit;
      i_bit       = 1'b1;
      @(negedge i_clk);
      i_start     = 1'b0;
      i_bit_valid = 1'b0;
      n_checks++;
      if (o_tp1_valid !== 1'b0 || o_all_tp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL valid_after_start: got %b%b expected 00", o_tp1_valid, o_all_tp_valid);
      end
   endtask

   task automatic send_bits(input int hi, input int lo, input bit gaps);
      for (int i = hi; i >= lo; i--) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            i_bit_valid = 1'b0;
            i_bit       = 1'($urandom_range(0, 1));
            @(negedge i_clk);
         end
         n_checks++;
         if (o_tp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_early at bit %0d: got %b expected 0", i, o_tp1_valid);
         end
         i_bit_valid = 1'b1;
         i_bit       = word[i];
         @(negedge i_clk);
      end
      i_bit_valid = 1'b0;
   endtask

   // Called at the first falling edge after the last bit was accepted.
   task automatic check_word(input string name, input bit mode);
      n_checks++;
      if (o_tp1_valid !== 1'b1 || o_all_tp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s latency1: got tp1_valid=%b all_valid=%b expected 1,0",
                  name, o_tp1_valid, o_all_tp_valid);
      end
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (got[0][j] !== exp_s[0][j]) begin
            n_fail++;
            $display("FAIL %s tp1 S%0d: got %h expected %h", name, 2 * j + 1, got[0][j], exp_s[0][j]);
         end
      end
      @(negedge i_clk);
      n_checks++;
      if (o_all_tp_valid !== (TP_EN && mode) || o_tp1_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s latency2: got tp1_valid=%b all_valid=%b expected 1,%b",
                  name, o_tp1_valid, o_all_tp_valid, TP_EN && mode);
      end
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (got[k][j] !== exp_s[k][j]) begin
               n_fail++;
               $display("FAIL %s tp%0d S%0d: got %h expected %h", name, k + 1, 2 * j + 1,
                        got[k][j], exp_s[k][j]);
            end
         end
      $display("word %s: tp1 S1..S7 = %h %h %h %h, tp4 = %h %h %h %h", name,
               got[0][0], got[0][1], got[0][2], got[0][3],
               got[3][0], got[3][1], got[3][2], got[3][3]);
   endtask

   task automatic run_word(input string name, input int code, input bit mode,
                           input int l1, input int l2, input bit gaps);
      model(code, mode, l1, l2);
      start_word(code, mode, l1, l2, 1'b0);
      send_bits(n_of(code) - 1, 0, gaps);
      check_word(name, mode);
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_code = 2'b00;
      i_lrb1_idx = '0; i_lrb2_idx = '0; i_bit_valid = 1'b0; i_bit = 1'b0;
      repeat (3) @(negedge i_clk);
      check_all_zero("reset");
      i_rst = 1'b0;
      i_bit_valid = 1'b1;
      i_bit = 1'b1;
      repeat (5) @(negedge i_clk);
      i_bit_valid = 1'b0;
      check_all_zero("idle_bits_ignored");
   endtask

   task automatic test_single_bits();
      fill_zero();
      run_word("zero63", 0, 1'b0, 0, 0, 1'b0);
      word[0] = 1'b1;
      run_word("r0_63", 0, 1'b0, 0, 0, 1'b0);
      fill_zero();
      word[1] = 1'b1;
      run_word("r1_1023", 2, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_soft();
      fill_zero();
      word[1] = 1'b1;
      run_word("soft_r1_1023", 2, 1'b1, 1, 5, 1'b0);
      for (int t = 0; t < 4; t++) begin
         int l1, l2;
         l1 = $urandom_range(0, 300);
         l2 = (t == 1) ? l1 : $urandom_range(0, 300);
         fill_random(255);
         run_word($sformatf("soft255_%0d", t), 1, 1'b1, l1, l2, 1'b1);
      end
      fill_random(1023);
      run_word("soft_code11", 3, 1'b1, $urandom_range(0, 1022), 1023, 1'b0);
   endtask

   task automatic test_gaps();
      fill_random(255);
      run_word("gaps255", 1, 1'b0, 0, 0, 1'b1);
      run_word("nogaps255", 1, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_abort_reset();
      fill_random(255);
      start_word(1, 1'b1, 7, 9, 1'b0);
      send_bits(254, 101, 1'b0);
      i_rst = 1'b1;
      #1;
      check_all_zero("abort_reset");
      @(negedge i_clk);
      i_rst = 1'b0;
      fill_zero();
      run_word("zero_after_reset", 1, 1'b1, 7, 9, 1'b0);
   endtask

   task automatic test_abort_start();
      fill_random(255);
      run_word("before_abort", 1, 1'b1, 3, 200, 1'b0);
      start_word(1, 1'b1, 3, 200, 1'b0);
      send_bits(254, 101, 1'b0);
      fill_zero();
      model(1, 1'b1, 3, 200);
      start_word(1, 1'b1, 3, 200, 1'b1);
      send_bits(254, 0, 1'b0);
      check_word("zero_after_restart", 1'b1);
   endtask

   initial begin
      test_reset();
      test_single_bits();
      test_soft();
      test_gaps();
      test_abort_reset();
      test_abort_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
